// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 chunk arbiter and its compression core.
package sha256_pkg;

  localparam int CHUNK_W = 512;
  localparam int STATE_W = 256;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;
  localparam logic [STATE_W-1:0] IV = {H0, H1, H2, H3, H4, H5, H6, H7};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } arb_state_t;

  // Listed in round order, so round t lives at index 63-t.
  localparam logic [63:0][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_word(input int t);
    return K_TABLE[63-t];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Final digest: eight independent mod-2^32 adds of the IV onto the core's a..h.
  function automatic logic [STATE_W-1:0] iv_add(input logic [STATE_W-1:0] st);
    logic [STATE_W-1:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = IV[32*j +: 32] + st[32*j +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_512chunk.sv
// Unpipelined combinational SHA-256 compression of one chunk starting from the IV.
// Outputs the final working variables a..h; the IV add is left to the caller.
module sha256_512chunk
  import sha256_pkg::*;
(
  input  logic [CHUNK_W-1:0] chunk,
  output logic [STATE_W-1:0] state
);

  always_comb begin
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = chunk[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = IV;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_word(t) + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g;
      g = f;
      f = e;
      e = d + t1;
      d = c;
      c = b;
      b = a;
      a = t1 + t2;
    end
    state = {a, b, c, d, e, f, g, h};
  end

endmodule

// File: rtl/sha256_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod NUM_REQ) wins.
module sha256_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Walk from the farthest candidate down to ptr+1 so the closest valid one overwrites.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sha256_chunk_arbiter.sv
// Shares one multicycle SHA-256 compression core between NUM_REQ requesters, round-robin.
//   state  | meaning
//   IDLE   | offering req_ready to the next round-robin requester
//   SETTLE | chunk held on the core while its combinational path settles
//   OUT    | digest presented, waiting for dgst_ready
module sha256_chunk_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CHUNKSIZE     = 512,
  parameter int SETTLE_CYCLES = 8,
  parameter int ID_W          = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CHUNKSIZE-1:0] req_chunk,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [CHUNKSIZE-1:0]         core_chunk,
  input  logic [STATE_W-1:0]           core_state,
  output logic                         dgst_valid,
  input  logic                         dgst_ready,
  output logic [ID_W-1:0]              dgst_id,
  output logic [STATE_W-1:0]           dgst_hash,
  output logic                         busy,
  output logic [15:0]                  done_cnt
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr, grant_idx, id_q;
  logic [NUM_REQ-1:0] grant;
  logic [CNT_W-1:0]   cnt;
  logic               accept, capture, handshake;

  sha256_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (dgst_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      id_q       <= '0;
      core_chunk <= '0;
      dgst_valid <= 1'b0;
      dgst_id    <= '0;
      dgst_hash  <= '0;
      done_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        core_chunk <= req_chunk[int'(grant_idx)*CHUNKSIZE +: CHUNKSIZE];
        id_q       <= grant_idx;
        rr_ptr     <= grant_idx;
        cnt        <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (state_q == SETTLE && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        dgst_hash  <= iv_add(core_state);
        dgst_id    <= id_q;
        dgst_valid <= 1'b1;
      end
      if (handshake) begin
        dgst_valid <= 1'b0;
        done_cnt   <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_chunk_arbiter.sv
// Scoreboard bench for sha256_chunk_arbiter driving a real sha256_512chunk core.
module tb_sha256_chunk_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CHUNKSIZE = 512;
  localparam int SETTLE = 8;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*CHUNKSIZE-1:0] req_chunk;
  logic [NUM_REQ-1:0] req_ready;
  logic [CHUNKSIZE-1:0] core_chunk;
  logic [255:0] core_state;
  logic dgst_valid, dgst_ready;
  logic [ID_W-1:0] dgst_id;
  logic [255:0] dgst_hash;
  logic busy;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  sha256_chunk_arbiter #(
    .NUM_REQ(NUM_REQ), .CHUNKSIZE(CHUNKSIZE), .SETTLE_CYCLES(SETTLE), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_chunk(req_chunk),
    .req_ready(req_ready), .core_chunk(core_chunk), .core_state(core_state),
    .dgst_valid(dgst_valid), .dgst_ready(dgst_ready), .dgst_id(dgst_id),
    .dgst_hash(dgst_hash), .busy(busy), .done_cnt(done_cnt)
  );

  sha256_512chunk u_core (.chunk(core_chunk), .state(core_state));

  // ---------------- reference model ----------------
  int unsigned k_tb [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_ref(logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hs [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[32*t +: 32];
      else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    v = hs;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tb[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = hs[j] + v[j];
    return r;
  endfunction

  function automatic logic [511:0] rand_chunk();
    logic [511:0] c;
    for (int j = 0; j < 16; j++) c[32*j +: 32] = $urandom;
    return c;
  endfunction

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [255:0]    hash;
    int              acc_edge;
  } exp_t;

  exp_t sb_q [$];
  exp_t ent;
  int hs_ids [$];
  logic [511:0] chunks [NUM_REQ];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int model_ptr;
  bit model_idle;
  logic [15:0] model_done;
  bit prev_valid;
  logic [255:0] held_hash, last_hash;
  logic [ID_W-1:0] held_id, last_id;
  logic [NUM_REQ-1:0] exp_rdy;
  int exp_i, cand;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    sb_q.delete();
    model_ptr = NUM_REQ - 1;
    model_idle = 1'b1;
    model_done = 16'h0;
    prev_valid = 1'b0;
  endtask

  task automatic set_chunk(input int i, input logic [511:0] c);
    chunks[i] = c;
    req_chunk[i*CHUNKSIZE +: CHUNKSIZE] = c;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Predict grants and check digests at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", {255'h0, busy}, {255'h0, !model_idle});
      check("ready_onehot0", {255'h0, $onehot0(req_ready)}, 256'h1);
      exp_rdy = '0;
      exp_i = -1;
      if (model_idle) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = (model_ptr + k) % NUM_REQ;
          if (exp_i < 0 && req_valid[cand]) exp_i = cand;
        end
      end
      if (exp_i >= 0) exp_rdy[exp_i] = 1'b1;
      check("req_ready", {252'h0, req_ready}, {252'h0, exp_rdy});
      if (exp_i >= 0) begin
        model_ptr = exp_i;
        model_idle = 1'b0;
        ent.id = ID_W'(exp_i);
        ent.hash = sha_ref(chunks[exp_i]);
        ent.acc_edge = cyc + 1;
        sb_q.push_back(ent);
      end

      if (dgst_valid) begin
        if (!prev_valid) begin
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_digest: got dgst_valid=1 expected no digest (cycle %0d)", cyc);
          end else begin
            check("latency", 256'(cyc), 256'(sb_q[0].acc_edge + SETTLE));
          end
          held_hash = dgst_hash;
          held_id = dgst_id;
        end else begin
          check("hold_hash", dgst_hash, held_hash);
          check("hold_id", {254'h0, dgst_id}, {254'h0, held_id});
        end
        if (dgst_ready && sb_q.size() > 0) begin
          ent = sb_q.pop_front();
          check("dgst_id", {254'h0, dgst_id}, {254'h0, ent.id});
          check("dgst_hash", dgst_hash, ent.hash);
          check("done_cnt", {240'h0, done_cnt}, {240'h0, model_done});
          model_done = model_done + 16'd1;
          model_idle = 1'b1;
          hs_ids.push_back(int'(dgst_id));
          last_hash = dgst_hash;
          last_id = dgst_id;
        end
      end
      prev_valid = dgst_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_accept(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (!model_idle) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL accept_timeout: got no grant expected grant within %0d cycles", budget);
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (model_idle && sb_q.size() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL done_timeout: got pending=%0d expected 0 within %0d cycles", sb_q.size(), budget);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req_valid = '0;
    req_chunk = '0;
    dgst_ready = 1'b1;
    last_hash = '0;
    last_id = '0;
    clear_model();
    for (int i = 0; i < NUM_REQ; i++) chunks[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {255'h0, busy}, 256'h0);
    check("rst_dgst_valid", {255'h0, dgst_valid}, 256'h0);
    check("rst_dgst_id", {254'h0, dgst_id}, 256'h0);
    check("rst_dgst_hash", dgst_hash, 256'h0);
    check("rst_done_cnt", {240'h0, done_cnt}, 256'h0);
    check("rst_core_chunk", {256'h0, core_chunk}, 768'h0);
    check("rst_req_ready", {252'h0, req_ready}, 256'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // "abc"
    set_chunk(0, {32'h18, 448'h0, 32'h61626380});
    req_valid = 4'b0001;
    wait_accept(20);
    req_valid = '0;
    wait_done(60);
    check("abc_hash", last_hash, 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    check("abc_id", {254'h0, last_id}, 256'h0);

    // Empty message
    set_chunk(2, {480'h0, 32'h80000000});
    req_valid = 4'b0100;
    wait_accept(20);
    req_valid = '0;
    wait_done(60);
    check("empty_hash", last_hash, 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
    check("empty_id", {254'h0, last_id}, 256'h2);
    check("empty_done_cnt", {240'h0, done_cnt}, 256'h2);

    // Fairness from reset with everyone valid
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_chunk(i, rand_chunk());
    hs_ids.delete();
    req_valid = '1;
    for (int n = 0; n < 200 && hs_ids.size() < 5; n++) begin
      @(posedge clk);
      #1;
      set_chunk($urandom_range(0, NUM_REQ - 1), rand_chunk());
    end
    req_valid = '0;
    wait_done(60);
    for (int i = 0; i < 5; i++)
      check("grant_order", 256'(i < hs_ids.size() ? hs_ids[i] : -1), 256'(exp_order[i]));

    // Random traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      req_valid = NUM_REQ'($urandom);
      dgst_ready = ($urandom_range(0, 3) != 0);
      set_chunk($urandom_range(0, NUM_REQ - 1), rand_chunk());
    end
    req_valid = '0;
    dgst_ready = 1'b1;
    wait_done(60);

    // Long backpressure while others request
    dgst_ready = 1'b0;
    set_chunk(1, rand_chunk());
    req_valid = 4'b0010;
    wait_accept(20);
    req_valid = '1;
    for (int n = 0; n < 40 && !dgst_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid_seen", {255'h0, dgst_valid}, 256'h1);
    repeat (20) @(posedge clk);
    #1;
    req_valid = '0;
    dgst_ready = 1'b1;
    wait_done(60);

    // Reset while settling with cnt==3
    do_reset();
    set_chunk(3, rand_chunk());
    req_valid = 4'b1000;
    wait_accept(20);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_model();
    #1;
    check("midjob_busy", {255'h0, busy}, 256'h0);
    check("midjob_dgst_valid", {255'h0, dgst_valid}, 256'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (SETTLE + 6) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) set_chunk(i, rand_chunk());
    req_valid = '1;
    wait_accept(20);
    req_valid = '0;
    wait_done(60);
    check("post_reset_grant", {254'h0, last_id}, 256'h0);

    // done_cnt wrap
    force dut.done_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.done_cnt;
    model_done = 16'hFFFF;
    set_chunk(1, rand_chunk());
    req_valid = 4'b0010;
    wait_accept(20);
    req_valid = '0;
    wait_done(60);
    check("done_cnt_wrap", {240'h0, done_cnt}, 256'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
